// File: rtl/reg_file_dumper.sv
// -----------------------------------------------------------------------------
// reg_file_dumper
//
// Purpose:
//   Debug / context-save master for the register file. A start pulse makes the
//   block walk read port A over addresses 0..NUM_REGS-1. Each {address, data}
//   pair is streamed out on a valid/ready port. In clear mode each register is
//   written back to zero after its beat has been accepted. The read-A and write
//   ports are only meaningful while busy_o is high.
//
// Ports:
//   clk_i             single clock, all state on the rising edge
//   reset_i           synchronous, active-high reset
//   start_i           begin a dump (only looked at while idle)
//   clear_mode_i      latched together with start_i; 1 = zero each register
//   busy_o            high from the cycle after an accepted start until DONE exits
//   done_o            one-cycle pulse at the end of the walk
//   read_address_a_o  register file read port A address (0 while idle)
//   read_data_a_i     register file read port A data (combinational read)
//   write_address_o   register file write address
//   write_en_o        register file write enable (single-cycle pulses)
//   write_data_o      register file write data, always zero
//   dump_valid_o      dump_address_o / dump_data_o hold a beat
//   dump_ready_i      consumer takes the beat when valid and ready are both high
//   dump_address_o    register index of the current beat
//   dump_data_o       register contents of the current beat
// -----------------------------------------------------------------------------
module reg_file_dumper #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              clear_mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] read_address_a_o,
  input  logic [DATA_W-1:0] read_data_a_i,
  output logic [ADDR_W-1:0] write_address_o,
  output logic              write_en_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_address_o,
  output logic [DATA_W-1:0] dump_data_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_SEND  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q,      state_d;
  logic [ADDR_W-1:0]   cnt_q,        cnt_d;
  logic                clear_mode_q, clear_mode_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;
  logic                dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0]   dump_addr_q,  dump_addr_d;
  logic [DATA_W-1:0]   dump_data_q,  dump_data_d;
  logic                write_en_q,   write_en_d;
  logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
  logic                advance_s;

  // State and registered outputs; reset aborts a walk on the very next edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= ADDR_ZERO;
      clear_mode_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= ADDR_ZERO;
      dump_data_q  <= {DATA_W{1'b0}};
      write_en_q   <= 1'b0;
      write_addr_q <= ADDR_ZERO;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_mode_q <= clear_mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
    end
  end

  // Next-state and next-output logic for the walk.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_mode_d = clear_mode_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    done_d       = 1'b0;
    advance_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The counter doubles as the read address, so it is parked at 0 here.
        cnt_d        = ADDR_ZERO;
        write_addr_d = ADDR_ZERO;
        if (start_i) begin
          clear_mode_d = clear_mode_i;
          state_d      = ST_READ;
        end else begin
          clear_mode_d = clear_mode_q;
        end
      end
      ST_READ: begin
        // Data is captured here, before any clear, so a beat is never zeroed.
        dump_data_d  = read_data_a_i;
        dump_addr_d  = cnt_q;
        dump_valid_d = 1'b1;
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        if (dump_valid_q && dump_ready_i) begin
          dump_valid_d = 1'b0;
          if (clear_mode_q) begin
            write_en_d   = 1'b1;
            write_addr_d = cnt_q;
            state_d      = ST_CLEAR;
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_CLEAR: begin
        advance_s = 1'b1;
      end
      ST_DONE: begin
        cnt_d   = ADDR_ZERO;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = ADDR_ZERO;
        state_d = ST_IDLE;
      end
    endcase

    // Shared step to the next register; the counter stops at the last address.
    if (advance_s) begin
      if (cnt_q == LAST_ADDR) begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end else begin
        cnt_d   = cnt_q + ADDR_ONE;
        state_d = ST_READ;
      end
    end else begin
      done_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign read_address_a_o = cnt_q;
  assign write_address_o  = write_addr_q;
  assign write_en_o       = write_en_q;
  assign write_data_o     = {DATA_W{1'b0}};
  assign dump_valid_o     = dump_valid_q;
  assign dump_address_o   = dump_addr_q;
  assign dump_data_o      = dump_data_q;

endmodule

// File: tb/tb_reg_file_dumper.sv
// -----------------------------------------------------------------------------
// tb_reg_file_dumper
//
// Directed bench for reg_file_dumper. A 32-entry instance is attached to a
// small register file model; a second instance with a single register checks
// the degenerate walk. Inputs change 2 time units after a rising edge and
// outputs are observed there or on the falling edge.
// -----------------------------------------------------------------------------
module tb_reg_file_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, clear_mode, dump_ready;
  logic        busy, done, we, valid;
  logic [15:0] ra, wa, da;
  logic [31:0] rd, wd, dd;

  logic        start1, ready1;
  logic        busy1, done1, we1, valid1;
  logic [15:0] ra1, wa1, da1;
  logic [31:0] rd1, wd1, dd1;

  logic [31:0] rf [0:31];
  logic        preload_req;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mon_addr [0:511];
  logic [31:0] mon_data [0:511];
  logic [15:0] mon_waddr [0:511];
  logic [31:0] mon_wdata [0:511];
  int beat_cnt = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  reg_file_dumper #(.NUM_REGS(32), .ADDR_W(16), .DATA_W(32)) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .clear_mode_i(clear_mode),
    .busy_o(busy), .done_o(done), .read_address_a_o(ra), .read_data_a_i(rd),
    .write_address_o(wa), .write_en_o(we), .write_data_o(wd),
    .dump_valid_o(valid), .dump_ready_i(dump_ready),
    .dump_address_o(da), .dump_data_o(dd)
  );

  reg_file_dumper #(.NUM_REGS(1), .ADDR_W(16), .DATA_W(32)) u_one (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .clear_mode_i(1'b0),
    .busy_o(busy1), .done_o(done1), .read_address_a_o(ra1), .read_data_a_i(rd1),
    .write_address_o(wa1), .write_en_o(we1), .write_data_o(wd1),
    .dump_valid_o(valid1), .dump_ready_i(ready1),
    .dump_address_o(da1), .dump_data_o(dd1)
  );

  // Register file model: combinational read, write on the rising edge.
  assign rd  = rf[ra[4:0]];
  assign rd1 = (ra1 == 16'd0) ? 32'hDEADBEEF : 32'h0000_0000;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i + 2);
    end else if (we) begin
      rf[wa[4:0]] <= wd;
    end
  end

  // Record accepted beats, write pulses and done pulses of the 32-entry DUT.
  always @(negedge clk) begin
    if (valid && dump_ready && beat_cnt < 512) begin
      mon_addr[beat_cnt] = da;
      mon_data[beat_cnt] = dd;
      beat_cnt++;
    end
    if (we && wr_cnt < 512) begin
      mon_waddr[wr_cnt] = wa;
      mon_wdata[wr_cnt] = wd;
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic preload();
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
  endtask

  // Runs one walk of the 32-entry DUT and checks its beats, cycle count and done.
  task automatic walk(input string name, input logic clr, input int stall_beat,
                      input int restart_beat, input int exp_cycles);
    int b0, d0, n, stall;
    bit restarted;
    b0 = beat_cnt; d0 = done_cnt;
    n = 0; stall = 0; restarted = 1'b0;
    start = 1'b1; clear_mode = clr; dump_ready = 1'b1;
    while (n < 400 && done !== 1'b1) begin
      step();
      n++;
      start = 1'b0;
      clear_mode = clr;
      if (restart_beat >= 0 && !restarted && valid && da == 16'(restart_beat)) begin
        start = 1'b1;
        clear_mode = ~clr;
        restarted = 1'b1;
      end
      if (stall_beat >= 0 && valid && da == 16'(stall_beat) && stall < 7) begin
        n_chk++;
        if (dd !== 32'(stall_beat + 2)) begin
          n_fail++;
          $display("FAIL %s stall_hold: data %h, required %h", name, dd, 32'(stall_beat + 2));
        end
        dump_ready = 1'b0;
        stall++;
      end else begin
        dump_ready = 1'b1;
      end
    end
    n_chk++;
    if (n !== exp_cycles) begin
      n_fail++;
      $display("FAIL %s cycles_to_done: %0d, required %0d", name, n, exp_cycles);
    end
    step();
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_done: busy=%b done=%b, required 0 0", name, busy, done);
    end
    n_chk++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: %0d, required 1", name, done_cnt - d0);
    end
    n_chk++;
    if (beat_cnt - b0 !== 32) begin
      n_fail++;
      $display("FAIL %s beat_count: %0d, required 32", name, beat_cnt - b0);
    end
    for (int i = 0; i < 32; i++) begin
      n_chk++;
      if (mon_addr[b0 + i] !== 16'(i) || mon_data[b0 + i] !== 32'(i + 2)) begin
        n_fail++;
        $display("FAIL %s beat%0d: (%0d,%h), required (%0d,%h)", name, i,
                 mon_addr[b0 + i], mon_data[b0 + i], i, 32'(i + 2));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_chk++;
    if ({busy, done, valid, we} !== 4'b0000 || ra !== 16'd0 || wa !== 16'd0 ||
        da !== 16'd0 || dd !== 32'd0 || wd !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b valid=%b we=%b ra=%h wa=%h da=%h dd=%h wd=%h, required all 0",
               busy, done, valid, we, ra, wa, da, dd, wd);
    end
    n_chk++;
    if ({busy1, done1, valid1, we1} !== 4'b0000 || ra1 !== 16'd0 || dd1 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_one: busy=%b done=%b valid=%b we=%b, required 0", busy1, done1, valid1, we1);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_latency();
    int n;
    preload();
    start = 1'b1; clear_mode = 1'b0; dump_ready = 1'b1;
    step();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_first_cycle: busy=%b valid=%b, required 1 0", busy, valid);
    end
    step();
    n_chk++;
    if (valid !== 1'b1 || da !== 16'd0 || dd !== 32'd2) begin
      n_fail++;
      $display("FAIL latency_first_beat: valid=%b (%0d,%h), required 1 (0,2)", valid, da, dd);
    end
    n = 0;
    while (n < 200 && busy === 1'b1) begin
      step();
      n++;
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_walk_end: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_plain();
    int w0;
    preload();
    w0 = wr_cnt;
    walk("plain", 1'b0, -1, -1, 65);
    n_chk++;
    if (wr_cnt - w0 !== 0) begin
      n_fail++;
      $display("FAIL plain_no_writes: %0d write cycles, required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_clear();
    int w0;
    preload();
    w0 = wr_cnt;
    walk("clear", 1'b1, -1, -1, 97);
    n_chk++;
    if (wr_cnt - w0 !== 32) begin
      n_fail++;
      $display("FAIL clear_write_count: %0d, required 32", wr_cnt - w0);
    end
    for (int i = 0; i < 32; i++) begin
      n_chk++;
      if (mon_waddr[w0 + i] !== 16'(i) || mon_wdata[w0 + i] !== 32'd0 || rf[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL clear_write%0d: addr=%0d data=%h reg=%h, required %0d 0 0",
                 i, mon_waddr[w0 + i], mon_wdata[w0 + i], rf[i], i);
      end
    end
  endtask

  task automatic test_stall();
    preload();
    walk("stall", 1'b0, 5, -1, 72);
  endtask

  task automatic test_back_to_back();
    int w0;
    preload();
    w0 = wr_cnt;
    walk("restart", 1'b0, -1, 10, 65);
    n_chk++;
    if (wr_cnt - w0 !== 0) begin
      n_fail++;
      $display("FAIL restart_clear_ignored: %0d write cycles, required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bit bad;
    preload();
    start = 1'b1; clear_mode = 1'b1; dump_ready = 1'b1;
    n = 0;
    while (n < 200 && !(we === 1'b1 && wa == 16'd12)) begin
      step();
      n++;
      start = 1'b0;
    end
    n_chk++;
    if (we !== 1'b1 || wa !== 16'd12) begin
      n_fail++;
      $display("FAIL abort_reach_clear12: we=%b wa=%0d, required 1 12", we, wa);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++;
    if ({busy, done, valid, we} !== 4'b0000 || ra !== 16'd0 || wa !== 16'd0 ||
        da !== 16'd0 || dd !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b done=%b valid=%b we=%b ra=%h wa=%h da=%h dd=%h, required all 0",
               busy, done, valid, we, ra, wa, da, dd);
    end
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (busy !== 1'b0 || we !== 1'b0 || valid !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL abort_stays_idle: activity after reset, required none");
    end
    for (int i = 0; i < 32; i++) begin
      n_chk++;
      if ((i >= 13 && rf[i] !== 32'(i + 2)) || (i < 12 && rf[i] !== 32'd0)) begin
        n_fail++;
        $display("FAIL abort_reg%0d: %h, required %h", i, rf[i], (i >= 13) ? 32'(i + 2) : 32'd0);
      end
    end
  endtask

  task automatic test_single();
    start1 = 1'b1; ready1 = 1'b1;
    step();
    start1 = 1'b0;
    n_chk++;
    if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_start: busy=%b valid=%b, required 1 0", busy1, valid1);
    end
    step();
    n_chk++;
    if (valid1 !== 1'b1 || da1 !== 16'd0 || dd1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_beat: valid=%b (%0d,%h), required 1 (0,deadbeef)", valid1, da1, dd1);
    end
    step();
    n_chk++;
    if (done1 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: done=%b valid=%b busy=%b, required 1 0 1", done1, valid1, busy1);
    end
    step();
    n_chk++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || we1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: done=%b busy=%b we=%b, required 0 0 0", done1, busy1, we1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear_mode = 1'b0; dump_ready = 1'b0;
    start1 = 1'b0; ready1 = 1'b0; preload_req = 1'b0;
    test_reset();
    test_latency();
    test_plain();
    test_clear();
    test_stall();
    test_back_to_back();
    test_reset_mid_clear();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
